// File: rtl/sram_arbiter_2x.sv
// Round-robin arbiter that lets two requesters share one single-port SRAM.
// Ownership is granted in bursts of up to MAX_BURST beats. While a requester
// owns the port, its address, write data and write enable are muxed onto the
// SRAM. Read data comes back to the owner with a one-cycle valid flag.
module sram_arbiter_2x #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_DEPTH = 16,
    parameter int WORD_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    // requester 0
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [WORD_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic [WORD_WIDTH-1:0] rdata0,
    output logic                  rvalid0,
    // requester 1
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WORD_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic [WORD_WIDTH-1:0] rdata1,
    output logic                  rvalid1,
    // SRAM macro port
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [WORD_WIDTH-1:0] sram_din,
    output logic                  sram_we,
    output logic                  sram_clk,
    input  logic [WORD_WIDTH-1:0] sram_dout
);

    // One extra bit over the index range keeps MAX_BURST=1 at a legal width.
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (WORD_DEPTH != (1 << ADDR_WIDTH) || MAX_BURST < 1) begin : g_bad_param
            $error("sram_arbiter_2x: WORD_DEPTH must be 2**ADDR_WIDTH and MAX_BURST >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;     // most recent owner (0 or 1)
    logic [CNT_W-1:0] cnt_q, cnt_d;       // beats granted in the current burst
    logic             burst_last;

    assign sram_clk   = hclk;
    assign burst_last = (cnt_q == CNT_LAST);

    // Both read-data paths see the SRAM output; rvalidN qualifies ownership.
    assign rdata0 = sram_dout;
    assign rdata1 = sram_dout;

    // State register: FSM state, last owner and burst beat counter.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arbitration from IDLE and end-of-burst hand-over.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (req0 && !burst_last) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    // Burst over: hand straight to the other side if it waits.
                    cnt_d = '0;
                    if (req1) begin
                        state_d = OWN1;
                        last_d  = 1'b0;
                    end else if (req0) begin
                        state_d = OWN0;
                    end else begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end
                end
            end
            OWN1: begin
                if (req1 && !burst_last) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = '0;
                    if (req0) begin
                        state_d = OWN0;
                        last_d  = 1'b1;
                    end else if (req1) begin
                        state_d = OWN1;
                    end else begin
                        state_d = IDLE;
                        last_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: grants and the SRAM port mux follow the current owner.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        sram_we   = 1'b0;
        case (state_q)
            OWN0: begin
                gnt0      = req0;
                sram_addr = addr0;
                sram_din  = wdata0;
                sram_we   = req0 & we0;
            end
            OWN1: begin
                gnt1      = req1;
                sram_addr = addr1;
                sram_din  = wdata1;
                sram_we   = req1 & we1;
            end
            default: begin
                gnt0 = 1'b0;
                gnt1 = 1'b0;
            end
        endcase
    end

    // Read-return flags: a granted read beat yields valid data next cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end

endmodule
